// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_ctrl_pkg: FSM state constants for serial_add_ctrl, taken from serial_add_defs.vh
`include "serial_add_defs.vh"
package serial_add_ctrl_pkg;
   localparam logic [1:0] ST_IDLE = `S_IDLE;
   localparam logic [1:0] ST_RUN  = `S_RUN;
   localparam logic [1:0] ST_DONE = `S_DONE;
endpackage

// File: rtl/serial_add_defs.vh
// serial_add_defs: state encodings and default width shared by serial_add_ctrl and its bench
`ifndef SERIAL_ADD_DEFS_VH
`define SERIAL_ADD_DEFS_VH
`define S_IDLE 2'd0
`define S_RUN 2'd1
`define S_DONE 2'd2
`define SA_DEFAULT_W 8
`endif

// File: rtl/yAdder1.sv
// yAdder1: 1-bit full adder cell; a, b, cin in -> z (sum bit), cout (carry out)
module yAdder1 (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic z,
   output logic cout
);
   assign z    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial W-bit add/subtract, one bit per clock LSB first through a single yAdder1.
// Ports: clk, reset_n (sync active-low); start/sub/a/b request, sampled in IDLE or DONE;
// busy (RUN), done (one-cycle result pulse), sum/cout result held until the next accepted start.
// Optional: define SERIAL_ADD_OVF_EN to add the ovf (signed overflow) output.
`include "serial_add_defs.vh"
module serial_add_ctrl
   import serial_add_ctrl_pkg::*;
#(
   parameter int W = `SA_DEFAULT_W
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic         sub,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] sum,
   output logic         cout
`ifdef SERIAL_ADD_OVF_EN
   ,output logic        ovf
`endif
);
   logic [1:0]   state;
   logic [W-1:0] a_sh, b_sh, res_sh, res_nx;
   logic [5:0]   count;
   logic         carry, s, co, last;
   yAdder1 u_add (.a(a_sh[0]), .b(b_sh[0]), .cin(carry), .z(s), .cout(co));
   assign res_nx = {s, res_sh[W-1:1]};
   assign last   = count == 6'(W - 1);
   assign busy   = state == ST_RUN;
   assign done   = state == ST_DONE;
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state  <= ST_IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         carry  <= 1'b0;
         count  <= '0;
         sum    <= '0;
         cout   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         ovf    <= 1'b0;
`endif
      end else if (state == ST_RUN) begin
         a_sh   <= a_sh >> 1;
         b_sh   <= b_sh >> 1;
         res_sh <= res_nx;
         carry  <= co;
         count  <= count + 6'd1;
         if (last) begin
            state <= ST_DONE;
            sum   <= res_nx;
            cout  <= co;
`ifdef SERIAL_ADD_OVF_EN
            // on the MSB step, carry holds the carry into the MSB
            ovf   <= carry ^ co;
`endif
         end
      end else if (start) begin
         // subtract as a + ~b + 1: invert b and seed the carry with sub
         state <= ST_RUN;
         a_sh  <= a;
         b_sh  <= b ^ {W{sub}};
         carry <= sub;
         count <= '0;
      end else begin
         state <= ST_IDLE;
      end
   end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: table-driven, corner-case and randomized checks of serial_add_ctrl against an arithmetic model
`include "serial_add_defs.vh"
module tb_serial_add_ctrl;
   localparam int W = `SA_DEFAULT_W;
   typedef struct {
      logic [W-1:0] a, b;
      logic         sub;
      logic [W-1:0] s;
      logic         c, v, b2b;
   } vec_t;
   logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, sub = 1'b0;
   logic [W-1:0] a = '0, b = '0, sum;
   logic busy, done, cout;
`ifdef SERIAL_ADD_OVF_EN
   logic ovf;
`endif
   int vectors = 0, miscompares = 0;
   vec_t tbl[6];
   serial_add_ctrl #(.W(W)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .sub(sub), .a(a), .b(b),
      .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_ADD_OVF_EN
      ,.ovf(ovf)
`endif
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic issue(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic si);
      a = ai; b = bi; sub = si; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = $urandom; b = $urandom; sub = $urandom;
   endtask
   task automatic wait_done(input string nm, input logic [W-1:0] es, input logic ec, input logic ev);
      int n = 0, nb = 0;
      while (!done && n < 4 * W) begin
         if (busy) nb++;
         @(negedge clk);
         n++;
      end
      chk({nm, " latency"}, n, W);
      chk({nm, " busy cycles"}, nb, W);
      chk({nm, " busy at done"}, busy, 0);
      chk({nm, " sum"}, sum, es);
      chk({nm, " cout"}, cout, ec);
`ifdef SERIAL_ADD_OVF_EN
      chk({nm, " ovf"}, ovf, ev);
`else
      if (ev === 1'bx) chk({nm, " ovf model"}, ev, 0);
`endif
   endtask
   function automatic vec_t model(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic si);
      vec_t r;
      int sa, sb, sr;
      r.a = ai; r.b = bi; r.sub = si; r.b2b = 1'b0;
      sa = int'($signed(ai)); sb = int'($signed(bi));
      sr = si ? sa - sb : sa + sb;
      r.s = si ? ai - bi : ai + bi;
      r.c = si ? (ai >= bi) : ((int'(ai) + int'(bi)) >= (1 << W));
      r.v = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
      return r;
   endfunction
   initial begin
      int pulses;
      logic [W-1:0] got;
      vec_t m;
      tbl[0] = '{8'd100, 8'd27, 1'b0, 8'd127, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{8'd5, 8'd7, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{8'd7, 8'd5, 1'b1, 8'h02, 1'b1, 1'b0, 1'b1};
      tbl[4] = '{8'd127, 8'd1, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
      tbl[5] = '{8'h80, 8'd1, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
      start = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset sum", sum, 0);
      chk("reset cout", cout, 0);
`ifdef SERIAL_ADD_OVF_EN
      chk("reset ovf", ovf, 0);
`endif
      start = 1'b0;
      reset_n = 1'b1;
      @(negedge clk);
      chk("idle busy", busy, 0);
      for (int i = 0; i < 6; i++) begin
         issue(tbl[i].a, tbl[i].b, tbl[i].sub);
         wait_done($sformatf("tbl%0d", i), tbl[i].s, tbl[i].c, tbl[i].v);
         if (i == 5 || !tbl[i + 1].b2b) begin
            @(negedge clk);
            chk($sformatf("tbl%0d done pulse", i), done, 0);
            repeat (4) @(negedge clk);
            chk($sformatf("tbl%0d sum hold", i), sum, tbl[i].s);
         end
      end
      issue(8'd1, 8'd1, 1'b0);
      @(negedge clk);
      a = 8'd50; b = 8'd50; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      pulses = 0;
      got = '0;
      repeat (3 * W) begin
         if (done) begin pulses++; got = sum; end
         @(negedge clk);
      end
      chk("ignore pulses", pulses, 1);
      chk("ignore sum", got, 2);
      issue(8'd10, 8'd20, 1'b0);
      repeat (3) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      chk("abort busy", busy, 0);
      chk("abort done", done, 0);
      chk("abort sum", sum, 0);
      pulses = 0;
      repeat (3 * W) begin
         if (done) pulses++;
         @(negedge clk);
      end
      chk("abort no done", pulses, 0);
      issue(8'd10, 8'd20, 1'b0);
      wait_done("after abort", 8'd30, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         m = model(W'($urandom), W'($urandom), 1'($urandom));
         if ($urandom_range(0, 2) != 0) @(negedge clk);
         issue(m.a, m.b, m.sub);
         wait_done($sformatf("rand%0d", i), m.s, m.c, m.v);
      end
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
